// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller signal bundle: redirect/stall inputs, instruction-memory
// request/response channel and the buffered-instruction handshake to decode.
interface pc_fetch_ctrl_if;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_target;
    logic        io_stall;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_inst_valid;
    logic [31:0] io_inst;
    logic [31:0] io_inst_pc;
    logic        io_inst_ready;
    logic        io_misaligned;

    modport master (
        input  io_redirect_valid, io_redirect_target, io_stall,
        input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
        input  io_inst_ready,
        output io_imem_req_valid, io_imem_req_addr,
        output io_inst_valid, io_inst, io_inst_pc, io_misaligned
    );

    modport slave (
        output io_redirect_valid, io_redirect_target, io_stall,
        output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
        output io_inst_ready,
        input  io_imem_req_valid, io_imem_req_addr,
        input  io_inst_valid, io_inst, io_inst_pc, io_misaligned
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues fetches from pc,
// buffers one instruction for decode and handles redirects mid-flight.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    pc_fetch_ctrl_if.master io
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic [31:0] inst_buf, inst_buf_next;
    logic        drop, drop_next;
    logic        misaligned;
    logic        req_valid;
    logic        accept;

    always_comb begin
        req_valid = (state == S_REQ) && !io.io_stall && !io.io_redirect_valid;
        accept    = req_valid && io.io_imem_req_ready;
    end

    assign io.io_imem_req_valid = req_valid;
    assign io.io_imem_req_addr  = pc;
    assign io.io_inst_valid     = (state == S_HOLD) && !io.io_redirect_valid;
    assign io.io_inst           = inst_buf;
    // req_pc is frozen while an instruction is buffered, so it names io_inst
    assign io.io_inst_pc        = req_pc;
    assign io.io_misaligned     = misaligned;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_pc_next   = req_pc;
        inst_buf_next = inst_buf;
        drop_next     = drop;

        if (io.io_redirect_valid)
            pc_next = {io.io_redirect_target[31:2], 2'b00};
        else if (accept)
            pc_next = pc + 32'd4;

        case (state)
            S_REQ: begin
                if (accept) begin
                    req_pc_next = pc;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io.io_imem_resp_valid) begin
                    if (drop || io.io_redirect_valid) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        inst_buf_next = io.io_imem_resp_data;
                        state_next    = S_HOLD;
                    end
                end else if (io.io_redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (io.io_redirect_valid || io.io_inst_ready)
                    state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            pc         <= RESET_VECTOR;
            req_pc     <= RESET_VECTOR;
            inst_buf   <= '0;
            drop       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_pc     <= req_pc_next;
            inst_buf   <= inst_buf_next;
            drop       <= drop_next;
            misaligned <= io.io_redirect_valid && (|io.io_redirect_target[1:0]);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected instructions are queued when a
// response is driven and checked when decode sees io_inst_valid.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t sb[$];

    pc_fetch_ctrl_if io_if ();

    pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic wait_inst(input string tag);
        int unsigned n = 0;
        exp_t e;
        while (io_if.io_inst_valid !== 1'b1 && n < 8) begin
            tick();
            settle();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, io_if.io_inst_valid}, 32'd1);
        if (io_if.io_inst_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_inst"}, io_if.io_inst, e.data);
                chk({tag, "_pc"}, io_if.io_inst_pc, e.pc);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        io_if.io_redirect_valid  = 1'b0;
        io_if.io_redirect_target = '0;
        io_if.io_stall           = 1'b0;
        io_if.io_imem_req_ready  = 1'b0;
        io_if.io_imem_resp_valid = 1'b0;
        io_if.io_imem_resp_data  = '0;
        io_if.io_inst_ready      = 1'b0;

        // reset state
        repeat (2) tick();
        settle();
        chk("rst_inst_valid", {31'd0, io_if.io_inst_valid}, 32'd0);
        chk("rst_inst", io_if.io_inst, 32'd0);
        chk("rst_inst_pc", io_if.io_inst_pc, RV);
        chk("rst_misaligned", {31'd0, io_if.io_misaligned}, 32'd0);
        chk("rst_addr", io_if.io_imem_req_addr, RV);

        // first fetch after release
        reset = 1'b1;
        io_if.io_imem_req_ready = 1'b1;
        settle();
        chk("r35_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r35_req_addr", io_if.io_imem_req_addr, 32'h0);
        tick();
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'h0050_0093;
        sb.push_back('{pc: 32'h0, data: 32'h0050_0093});
        settle();
        chk("r35_wait_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        chk("r35_wait_inst_valid", {31'd0, io_if.io_inst_valid}, 32'd0);
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        io_if.io_inst_ready = 1'b1;
        settle();
        wait_inst("r35");
        chk("r35_hold_addr", io_if.io_imem_req_addr, 32'h4);
        tick();
        io_if.io_inst_ready = 1'b0;
        settle();
        chk("r35_next_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r35_next_addr", io_if.io_imem_req_addr, 32'h4);

        // redirect in WAIT drops the in-flight response
        tick();
        io_if.io_redirect_valid  = 1'b1;
        io_if.io_redirect_target = 32'h0000_0100;
        settle();
        chk("r36_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        tick();
        io_if.io_redirect_valid  = 1'b0;
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'hDEAD_BEEF;
        settle();
        chk("r36_inst_valid_a", {31'd0, io_if.io_inst_valid}, 32'd0);
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        settle();
        chk("r36_inst_valid_b", {31'd0, io_if.io_inst_valid}, 32'd0);
        chk("r36_req_valid_b", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r36_addr", io_if.io_imem_req_addr, 32'h100);

        // misaligned redirect
        io_if.io_redirect_valid  = 1'b1;
        io_if.io_redirect_target = 32'h0000_0202;
        settle();
        chk("r37_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        chk("r37_mis_before", {31'd0, io_if.io_misaligned}, 32'd0);
        tick();
        io_if.io_redirect_valid = 1'b0;
        settle();
        chk("r37_mis_pulse", {31'd0, io_if.io_misaligned}, 32'd1);
        chk("r37_addr", io_if.io_imem_req_addr, 32'h200);
        chk("r37_req_valid_b", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        tick();
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'h00A0_0113;
        sb.push_back('{pc: 32'h200, data: 32'h00A0_0113});
        settle();
        chk("r37_mis_after", {31'd0, io_if.io_misaligned}, 32'd0);
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        settle();
        wait_inst("r37");

        // HOLD without ready, then redirect together with ready
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("r38_hold_valid", {31'd0, io_if.io_inst_valid}, 32'd1);
        end
        io_if.io_redirect_valid  = 1'b1;
        io_if.io_redirect_target = 32'h0000_0040;
        io_if.io_inst_ready      = 1'b1;
        settle();
        chk("r38_masked_valid", {31'd0, io_if.io_inst_valid}, 32'd0);
        tick();
        io_if.io_redirect_valid = 1'b0;
        io_if.io_inst_ready     = 1'b0;
        io_if.io_imem_req_ready = 1'b0;
        settle();
        chk("r38_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r38_addr", io_if.io_imem_req_addr, 32'h40);
        chk("r38_inst_valid", {31'd0, io_if.io_inst_valid}, 32'd0);

        // pc wrap and stall
        io_if.io_redirect_valid  = 1'b1;
        io_if.io_redirect_target = 32'hFFFF_FFFC;
        settle();
        tick();
        io_if.io_redirect_valid = 1'b0;
        io_if.io_imem_req_ready = 1'b1;
        settle();
        chk("r39_top_addr", io_if.io_imem_req_addr, 32'hFFFF_FFFC);
        chk("r39_top_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        tick();
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'h0000_0013;
        sb.push_back('{pc: 32'hFFFF_FFFC, data: 32'h0000_0013});
        settle();
        chk("r39_wrap_addr", io_if.io_imem_req_addr, 32'h0);
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        io_if.io_inst_ready = 1'b1;
        settle();
        wait_inst("r39");
        tick();
        io_if.io_inst_ready = 1'b0;
        io_if.io_stall = 1'b1;
        settle();
        chk("r39_stall_valid", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        chk("r39_stall_addr", io_if.io_imem_req_addr, 32'h0);
        tick();
        settle();
        chk("r39_stall_valid_b", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        chk("r39_stall_addr_b", io_if.io_imem_req_addr, 32'h0);
        io_if.io_stall = 1'b0;
        settle();
        chk("r39_unstall_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r39_unstall_addr", io_if.io_imem_req_addr, 32'h0);

        // reset during WAIT, stale response afterwards
        tick();
        settle();
        chk("r40_wait_valid", {31'd0, io_if.io_imem_req_valid}, 32'd0);
        chk("r40_wait_addr", io_if.io_imem_req_addr, 32'h4);
        reset = 1'b0;
        settle();
        chk("r40_rst_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r40_rst_addr", io_if.io_imem_req_addr, RV);
        tick();
        reset = 1'b1;
        io_if.io_imem_req_ready  = 1'b0;
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'hBAD0_BAD0;
        settle();
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        settle();
        chk("r40_stale_inst_valid", {31'd0, io_if.io_inst_valid}, 32'd0);
        chk("r40_stale_req_valid", {31'd0, io_if.io_imem_req_valid}, 32'd1);
        chk("r40_stale_addr", io_if.io_imem_req_addr, RV);
        io_if.io_imem_req_ready = 1'b1;
        settle();
        tick();
        io_if.io_imem_resp_valid = 1'b1;
        io_if.io_imem_resp_data  = 32'h0010_0093;
        sb.push_back('{pc: RV, data: 32'h0010_0093});
        settle();
        tick();
        io_if.io_imem_resp_valid = 1'b0;
        settle();
        wait_inst("r40_refetch");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 io_redirect_valid  input  1  PC redirect request from the jump/branch/jalr target mux path.
REQ-005 io_redirect_target  input  32  redirect target address.
REQ-006 io_stall  input  1  suppresses issue of new fetch requests.
REQ-007 io_imem_req_valid  output  1  fetch request valid.
REQ-008 io_imem_req_ready  input  1  instruction memory accepts request.
REQ-009 io_imem_req_addr  output  32  fetch address, word aligned.
REQ-010 io_imem_resp_valid  input  1  fetch response valid, single cycle.
REQ-011 io_imem_resp_data  input  32  fetched instruction word.
REQ-012 io_inst_valid  output  1  buffered instruction available to decode.
REQ-013 io_inst  output  32  buffered instruction.
REQ-014 io_inst_pc  output  32  address of io_inst.
REQ-015 io_inst_ready  input  1  decode consumes instruction.
REQ-016 io_misaligned  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Function
REQ-017 Three-state FSM: REQ (issue fetch), WAIT (one outstanding fetch), HOLD (instruction buffered); at most one outstanding request.
REQ-018 Internal regs: pc (next fetch address), req_pc (address in flight), inst_buf, drop flag.
REQ-019 io_imem_req_valid = (state==REQ) & ~io_stall & ~io_redirect_valid; io_imem_req_addr = pc at all times.
REQ-020 REQ with request accepted (valid & ready): req_pc <= pc, pc <= pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), state -> WAIT.
REQ-021 WAIT with io_imem_resp_valid and drop=0: inst_buf <= resp_data, io_inst_pc source <= req_pc, state -> HOLD.
REQ-022 WAIT with io_imem_resp_valid and drop=1: response discarded, drop <= 0, state -> REQ.
REQ-023 io_imem_resp_valid outside WAIT is ignored; no state change.
REQ-024 io_inst_valid = (state==HOLD) & ~io_redirect_valid; io_inst = inst_buf.
REQ-025 HOLD with io_inst_valid & io_inst_ready: state -> REQ next cycle.
REQ-026 Redirect (any state): pc <= {target[31:2], 2'b00}; io_misaligned <= |target[1:0] next cycle, registered, 1 cycle wide.
REQ-027 Redirect in REQ: no request issued that cycle; next cycle requests the new pc.
REQ-028 Redirect in WAIT: drop <= 1 (unless resp_valid same cycle, which is discarded directly -> REQ, drop stays 0); remains in WAIT otherwise.
REQ-029 Redirect in HOLD: inst_buf invalidated, state -> REQ; simultaneous io_inst_ready is not a transfer.
REQ-030 io_stall affects REQ only; WAIT and HOLD proceed normally.
REQ-031 Minimum latency: request accept at cycle N, response at N+1, io_inst_valid at N+2.

Reset
REQ-032 While reset=0: state=REQ, pc=RESET_VECTOR, req_pc=RESET_VECTOR, drop=0, inst_buf=0, io_misaligned=0, io_inst_valid=0, io_inst=0, io_inst_pc=RESET_VECTOR.
REQ-033 Reset asserted mid-WAIT: outstanding response arriving after release is ignored (REQ-023).
REQ-034 First request after release: io_imem_req_valid=1 with addr=RESET_VECTOR in the first cycle, unless stalled.

Verification
REQ-035 Release reset, ready=1, resp 1 cycle later data 0x00500093 -> req addr 0x0, then io_inst_valid with io_inst=0x00500093, io_inst_pc=0x0; next req addr 0x4.
REQ-036 Redirect target 0x0000_0100 while in WAIT, resp data 0xDEADBEEF next cycle -> response dropped, io_inst_valid stays 0, next req addr 0x100.
REQ-037 Redirect target 0x0000_0202 -> io_misaligned pulses once, next req addr 0x200.
REQ-038 HOLD with io_inst_ready=0 for 5 cycles then io_redirect_valid and io_inst_ready together (target 0x40) -> no transfer, next req addr 0x40.
REQ-039 pc=0xFFFF_FFFC accepted -> next req addr 0x0; io_stall=1 in REQ -> io_imem_req_valid=0, addr held.
REQ-040 reset asserted in WAIT, released, stale resp_valid arrives -> ignored; req addr RESET_VECTOR.
